// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between an instruction
// fetch port (0, read-only) and a data load/store port (1), with ack timeout.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              p0_req_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic              err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_reg;
    logic                owner_reg;
    logic                last_grant_reg;
    logic [WAIT_W-1:0]   wait_reg;
    logic                mem_en_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [1:0]          ack_reg;
    logic                err_reg;
    logic [CNT_W-1:0]    conflict_reg;

    logic [1:0]          req_vec;
    logic                contended;
    logic                grant_next;
    logic [DATA_W-1:0]   rdata_vec [2];

    assign req_vec    = {p1_req_i, p0_req_i};
    assign contended  = &req_vec;
    // On contention the port that did not win last time gets the grant.
    assign grant_next = contended ? ~last_grant_reg : req_vec[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            wait_reg       <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            ack_reg        <= '0;
            err_reg        <= 1'b0;
            conflict_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i && (|req_vec)) begin
                        owner_reg      <= grant_next;
                        last_grant_reg <= grant_next;
                        mem_en_reg     <= 1'b1;
                        mem_we_reg     <= grant_next & p1_we_i;
                        mem_addr_reg   <= grant_next ? p1_addr_i : p0_addr_i;
                        mem_wdata_reg  <= grant_next ? p1_wdata_i : '0;
                        wait_reg       <= '0;
                        if (contended && (conflict_reg != {CNT_W{1'b1}}))
                            conflict_reg <= conflict_reg + CNT_W'(1);
                        state_reg      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A real ack wins over a timeout landing in the same cycle.
                    if (mem_ack_i || (wait_reg == WAIT_LAST)) begin
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        ack_reg    <= owner_reg ? 2'b10 : 2'b01;
                        err_reg    <= ~mem_ack_i;
                        state_reg  <= RESP;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                RESP: begin
                    ack_reg   <= '0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-port read data holders: load only on an acked read owned by that port.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            logic [DATA_W-1:0] rdata_reg;
            logic              capture;

            assign capture = (state_reg == ACCESS) && mem_ack_i && !mem_we_reg
                             && (owner_reg == 1'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i)
                    rdata_reg <= '0;
                else if (capture)
                    rdata_reg <= mem_rdata_i;
            end

            assign rdata_vec[gi] = rdata_reg;
        end
    endgenerate

    assign p0_ack_o       = ack_reg[0];
    assign p1_ack_o       = ack_reg[1];
    assign p0_rdata_o     = rdata_vec[0];
    assign p1_rdata_o     = rdata_vec[1];
    assign err_o          = err_reg;
    assign mem_en_o       = mem_en_reg;
    assign mem_we_o       = mem_we_reg;
    assign mem_addr_o     = mem_addr_reg;
    assign mem_wdata_o    = mem_wdata_reg;
    assign conflict_cnt_o = conflict_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of single transactions plus
// hand-written contention, start gating and mid-access reset sequences.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          p0_req = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0;
    logic          p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic          err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic [CW-1:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .p0_req_i      (p0_req),
        .p0_addr_i     (p0_addr),
        .p0_ack_o      (p0_ack),
        .p0_rdata_o    (p0_rdata),
        .p1_req_i      (p1_req),
        .p1_we_i       (p1_we),
        .p1_addr_i     (p1_addr),
        .p1_wdata_i    (p1_wdata),
        .p1_ack_o      (p1_ack),
        .p1_rdata_o    (p1_rdata),
        .err_o         (err),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_ack_i     (mem_ack),
        .conflict_cnt_o(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            delay;      // access cycles before mem ack; >= MW never acks
        logic [DW-1:0] rdata;
        int            exp_en;     // cycles mem_en is high
        logic          exp_we;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;  // owning port's rdata after the ack
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int   en_cycles;
        int   held_bad;
        @(negedge clk);
        p0_req   = ~v.port;
        p1_req   = v.port;
        p0_addr  = v.addr;
        p1_addr  = v.addr;
        p1_we    = v.we;
        p1_wdata = v.wdata;
        @(negedge clk);
        check("grant_latency", {63'd0, mem_en}, 64'd1);
        check("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr});
        check("mem_we", {63'd0, mem_we}, {63'd0, v.exp_we});
        en_cycles = 0;
        held_bad  = 0;
        while (mem_en === 1'b1 && en_cycles < 40) begin
            if (mem_addr !== v.addr || mem_we !== v.exp_we) held_bad++;
            mem_ack   = (en_cycles == v.delay);
            mem_rdata = (en_cycles == v.delay) ? v.rdata : 32'hBAD0BAD0;
            en_cycles++;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        p0_req  = 1'b0;
        p1_req  = 1'b0;
        check("access_cycles", 64'(en_cycles), 64'(v.exp_en));
        check("mem_held", 64'(held_bad), 64'd0);
        check("own_ack", {63'd0, v.port ? p1_ack : p0_ack}, 64'd1);
        check("other_ack", {63'd0, v.port ? p0_ack : p1_ack}, 64'd0);
        check("err", {63'd0, err}, {63'd0, v.exp_err});
        check("rdata", {32'd0, v.port ? p1_rdata : p0_rdata}, {32'd0, v.exp_rdata});
        @(negedge clk);
        check("ack_one_cycle", {62'd0, p1_ack, p0_ack}, 64'd0);
        check("err_cleared", {63'd0, err}, 64'd0);
        $display("txn %0d: port=%0d we=%0d addr=%h en_cycles=%0d err_exp=%0d", idx, v.port, v.we,
                 v.addr, en_cycles, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        logic exp_port;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,    0,   32'hDEADBEEF, 1, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h1234, 2,   32'hFFFF0000, 3, 1'b1, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h24, 32'h0,    1,   32'hCAFEF00D, 2, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b1, 32'h28, 32'hABCD, 0,   32'h11111111, 1, 1'b1, 1'b0, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b1, 32'h30, 32'h0,    0,   32'h22222222, 1, 1'b0, 1'b0, 32'h22222222};
        vecs[5] = '{1'b0, 1'b0, 32'h14, 32'h0,    100, 32'h33333333, 8, 1'b0, 1'b1, 32'h22222222};
        vecs[6] = '{1'b0, 1'b0, 32'h18, 32'h0,    7,   32'h55AA55AA, 8, 1'b0, 1'b0, 32'h55AA55AA};
        vecs[7] = '{1'b1, 1'b0, 32'h2C, 32'h0,    100, 32'h44444444, 8, 1'b0, 1'b1, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 1'b0, 32'h1C, 32'h0,    0,   32'h0BADC0DE, 1, 1'b0, 1'b0, 32'h0BADC0DE};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_en", {63'd0, mem_en}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("rst_acks", {62'd0, p1_ack, p0_ack}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_rdata", {p1_rdata, p0_rdata}, 64'd0);
        check("rst_cnt", {61'd0, conflict_cnt}, 64'd0);
        rst   = 1'b0;
        start = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);
        check("no_conflicts_yet", {61'd0, conflict_cnt}, 64'd0);

        // Contention from reset: alternating grants, counter saturates at 7
        @(negedge clk);
        rst     = 1'b1;
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        p0_addr = 32'h100;
        p1_addr = 32'h200;
        p1_we   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 9; g++) begin
            exp_port = g[0];
            found = 0;
            for (int w = 0; w < 10 && found == 0; w++) begin
                @(negedge clk);
                if (mem_en === 1'b1) found = 1;
            end
            check("cont_grant_seen", 64'(found), 64'd1);
            check("cont_grant_addr", {32'd0, mem_addr}, exp_port ? 64'h200 : 64'h100);
            check("cont_cnt", {61'd0, conflict_cnt}, (g < 7) ? 64'(g + 1) : 64'd7);
            mem_ack   = 1'b1;
            mem_rdata = 32'(g);
            @(negedge clk);
            mem_ack = 1'b0;
            check("cont_acks", {62'd0, p1_ack, p0_ack}, exp_port ? 64'd2 : 64'd1);
            $display("contention grant %0d: port=%0d cnt=%0d", g, exp_port, conflict_cnt);
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(negedge clk);

        // start gating, then drop start mid-access
        start   = 1'b0;
        p0_req  = 1'b1;
        p0_addr = 32'h40;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("gated_no_en", {63'd0, mem_en}, 64'd0);
        end
        start = 1'b1;
        @(negedge clk);
        check("start_grant", {63'd0, mem_en}, 64'd1);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("start_low_still_access", {63'd0, mem_en}, 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h77;
        @(negedge clk);
        mem_ack = 1'b0;
        p0_req  = 1'b0;
        check("start_low_ack", {62'd0, p1_ack, p0_ack}, 64'd1);
        check("start_low_rdata", {32'd0, p0_rdata}, 64'h77);
        $display("start gating txn: ack=%0d rdata=%h", p0_ack, p0_rdata);
        start = 1'b1;
        @(negedge clk);

        // Reset mid-ACCESS after a port-0 grant
        p0_req  = 1'b1;
        p0_addr = 32'h50;
        @(negedge clk);
        check("pre_rst_grant", {63'd0, mem_en}, 64'd1);
        rst    = 1'b1;
        p0_req = 1'b0;
        @(negedge clk);
        check("rst_abandon_en", {63'd0, mem_en}, 64'd0);
        check("rst_abandon_acks", {62'd0, p1_ack, p0_ack}, 64'd0);
        check("rst_abandon_cnt", {61'd0, conflict_cnt}, 64'd0);
        rst     = 1'b0;
        p0_req  = 1'b1;
        p1_req  = 1'b1;
        p0_addr = 32'h100;
        p1_addr = 32'h200;
        @(negedge clk);
        check("post_rst_acks", {62'd0, p1_ack, p0_ack}, 64'd0);
        check("post_rst_en", {63'd0, mem_en}, 64'd1);
        check("post_rst_winner", {32'd0, mem_addr}, 64'h100);
        check("post_rst_cnt", {61'd0, conflict_cnt}, 64'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        p0_req  = 1'b0;
        p1_req  = 1'b0;
        check("post_rst_ack", {62'd0, p1_ack, p0_ack}, 64'd1);
        $display("reset mid-access txn: winner addr=100 ack0=%0d", p0_ack);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
